trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Supervisor trap sequencer: latches an EX-stage trap, flushes, drains MEM/WB,
// commits to the CSR file, then redirects fetch. TRAP_CTRL_TIMER_IRQ_EN adds a timer interrupt.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [1:0]  ex_op,
  input  logic [63:0] ex_pc,
  input  logic [63:0] sstatus,
  input  logic [63:0] stvec,
  input  logic [63:0] sepc,
  input  logic        pipe_empty,
`ifdef TRAP_CTRL_TIMER_IRQ_EN
  input  logic        timer_cmp_we,
  input  logic [63:0] timer_cmp_wdata,
`endif
  output logic [1:0]  trap,
  output logic [63:0] trap_pc,
  output logic [63:0] trap_scause,
  output logic        flush,
  output logic        stall,
  output logic        redirect,
  output logic [63:0] redirect_pc,
  output logic        drain_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    DRAIN,
    COMMIT,
    REDIRECT
  } state_t;

  localparam logic [63:0] CAUSE_ECALL = 64'd8;
  localparam logic [63:0] CAUSE_UNIMP = 64'd2;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] cause_q, cause_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        to_q, to_d;
  logic        irq_take;

`ifdef TRAP_CTRL_TIMER_IRQ_EN
  localparam logic [63:0] CAUSE_STIMER = 64'h8000_0000_0000_0005;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        unused_sstatus;

  assign unused_sstatus = ^{sstatus[63:2], sstatus[0]};

  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = timer_cmp_we ? timer_cmp_wdata : mtimecmp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign irq_take = ex_valid && sstatus[1] && (mtime_q >= mtimecmp_q);
`else
  logic unused_sstatus;

  assign unused_sstatus = ^sstatus;
  assign irq_take       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    cnt_d   = '0;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        // Synchronous exceptions win; a pending interrupt waits for a clean IDLE cycle.
        if (ex_valid && ex_op != 2'b00) begin
          op_d    = ex_op;
          pc_d    = ex_pc;
          cause_d = (ex_op == 2'b01) ? CAUSE_ECALL :
                    (ex_op == 2'b10) ? CAUSE_UNIMP : '0;
          state_d = FLUSH;
        end else if (irq_take) begin
          op_d    = 2'b01;
          pc_d    = ex_pc;
`ifdef TRAP_CTRL_TIMER_IRQ_EN
          cause_d = CAUSE_STIMER;
`endif
          state_d = FLUSH;
        end
      end
      FLUSH: state_d = DRAIN;
      DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (pipe_empty) begin
          state_d = COMMIT;
        end else if (cnt_q == 8'd254) begin
          state_d = COMMIT;
          to_d    = 1'b1;
        end
      end
      COMMIT:   state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      pc_q    <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    trap        = '0;
    trap_pc     = '0;
    trap_scause = '0;
    flush       = 1'b0;
    stall       = (state_q != IDLE);
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state_q)
      FLUSH: flush = 1'b1;
      COMMIT: begin
        trap        = op_q;
        trap_pc     = pc_q;
        trap_scause = cause_q;
      end
      REDIRECT: begin
        redirect    = 1'b1;
        redirect_pc = (op_q == 2'b11) ? sepc : stvec;
      end
      default: ;
    endcase
  end

  assign drain_timeout = to_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl; the timer-interrupt section is
// compiled only when TRAP_CTRL_TIMER_IRQ_EN is defined.
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [1:0]  ex_op;
  logic [63:0] ex_pc;
  logic [63:0] sstatus;
  logic [63:0] stvec;
  logic [63:0] sepc;
  logic        pipe_empty;
  logic [1:0]  trap;
  logic [63:0] trap_pc;
  logic [63:0] trap_scause;
  logic        flush;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        drain_timeout;
`ifdef TRAP_CTRL_TIMER_IRQ_EN
  logic        timer_cmp_we;
  logic [63:0] timer_cmp_wdata;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  trap_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_op         (ex_op),
    .ex_pc         (ex_pc),
    .sstatus       (sstatus),
    .stvec         (stvec),
    .sepc          (sepc),
    .pipe_empty    (pipe_empty),
`ifdef TRAP_CTRL_TIMER_IRQ_EN
    .timer_cmp_we  (timer_cmp_we),
    .timer_cmp_wdata(timer_cmp_wdata),
`endif
    .trap          (trap),
    .trap_pc       (trap_pc),
    .trap_scause   (trap_scause),
    .flush         (flush),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .drain_timeout (drain_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Minimum-latency trap sequence with pipe_empty=1; event presented at call.
  task automatic run_trap(input string tag, input logic [1:0] op, input logic [63:0] pc,
                          input logic [63:0] exp_cause, input logic [63:0] exp_rpc);
    ex_valid = 1'b1; ex_op = op; ex_pc = pc; pipe_empty = 1'b1;
    tick();
    ex_valid = 1'b0; ex_op = 2'b00;
    check({tag, "_flush"}, 64'(flush), 64'd1);
    check({tag, "_flush_stall"}, 64'(stall), 64'd1);
    check({tag, "_flush_trap"}, 64'(trap), 64'd0);
    tick();
    check({tag, "_drain_flush"}, 64'(flush), 64'd0);
    check({tag, "_drain_stall"}, 64'(stall), 64'd1);
    tick();
    check({tag, "_commit_trap"}, 64'(trap), 64'(op));
    check({tag, "_commit_pc"}, trap_pc, pc);
    check({tag, "_commit_cause"}, trap_scause, exp_cause);
    tick();
    check({tag, "_redir"}, 64'(redirect), 64'd1);
    check({tag, "_redir_pc"}, redirect_pc, exp_rpc);
    check({tag, "_redir_trap"}, 64'(trap), 64'd0);
    tick();
    check({tag, "_idle_stall"}, 64'(stall), 64'd0);
    check({tag, "_idle_redir"}, 64'(redirect), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned k;
    int unsigned commits;
    int unsigned flushes;
    logic [63:0] seen_pc;

    rst = 1'b1; ex_valid = 1'b0; ex_op = 2'b00; ex_pc = '0;
    sstatus = '0; stvec = 64'h8020_0000; sepc = 64'h8020_0104; pipe_empty = 1'b1;
`ifdef TRAP_CTRL_TIMER_IRQ_EN
    timer_cmp_we = 1'b0; timer_cmp_wdata = '0;
`endif
    ex_valid = 1'b1; ex_op = 2'b01; ex_pc = 64'h1234;
    tick(); tick();
    check("rst_trap", 64'(trap), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_trap_pc", trap_pc, 64'd0);
    check("rst_rpc", redirect_pc, 64'd0);
    check("rst_timeout", 64'(drain_timeout), 64'd0);
    ex_valid = 1'b0; ex_op = 2'b00;
    rst = 1'b0;
    tick();

    run_trap("ecall", 2'b01, 64'h8020_0100, 64'd8, 64'h8020_0000);
    run_trap("sret", 2'b11, 64'h8020_0200, 64'd0, 64'h8020_0104);

    // Unimp with pipe_empty low during FLUSH and the first two DRAIN cycles.
    pipe_empty = 1'b0;
    ex_valid = 1'b1; ex_op = 2'b10; ex_pc = 64'h8020_0300;
    tick();
    ex_valid = 1'b0; ex_op = 2'b00;
    tick();
    k = 0;
    do begin
      k++;
      pipe_empty = (k >= 3);
      tick();
    end while (trap == 2'b00 && k < 20);
    check("drain3_cycles", 64'(k), 64'd3);
    check("drain3_trap", 64'(trap), 64'd2);
    check("drain3_cause", trap_scause, 64'd2);
    check("drain3_no_timeout", 64'(drain_timeout), 64'd0);
    tick(); tick();

    // Drain watchdog.
    pipe_empty = 1'b0;
    ex_valid = 1'b1; ex_op = 2'b10; ex_pc = 64'h8020_0400;
    tick();
    ex_valid = 1'b0; ex_op = 2'b00;
    tick();
    k = 0;
    do begin
      k++;
      tick();
    end while (trap == 2'b00 && k < 400);
    check("timeout_cycles", 64'(k), 64'd255);
    check("timeout_trap", 64'(trap), 64'd2);
    check("timeout_flag", 64'(drain_timeout), 64'd1);
    pipe_empty = 1'b1;
    tick(); tick();
    check("timeout_sticky", 64'(drain_timeout), 64'd1);

    // Second ecall presented during DRAIN must be ignored.
    pipe_empty = 1'b0;
    ex_valid = 1'b1; ex_op = 2'b01; ex_pc = 64'h8020_0500;
    tick();
    ex_valid = 1'b0; ex_op = 2'b00;
    tick();
    ex_valid = 1'b1; ex_op = 2'b01; ex_pc = 64'h8020_0600;
    commits = 0; flushes = 0; seen_pc = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        pipe_empty = 1'b1;
        ex_valid = 1'b0; ex_op = 2'b00;
      end
      tick();
      if (trap != 2'b00) begin
        commits++;
        seen_pc = trap_pc;
      end
      if (flush) flushes++;
    end
    check("b2b_commits", 64'(commits), 64'd1);
    check("b2b_pc", seen_pc, 64'h8020_0500);
    check("b2b_flushes", 64'(flushes), 64'd0);

    // Reset in COMMIT, then an event on the first edge after release.
    ex_valid = 1'b1; ex_op = 2'b01; ex_pc = 64'h8020_0700;
    tick();
    ex_valid = 1'b0; ex_op = 2'b00;
    tick(); tick();
    check("pre_rst_trap", 64'(trap), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_trap", 64'(trap), 64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_trap_pc", trap_pc, 64'd0);
    check("midrst_timeout", 64'(drain_timeout), 64'd0);
    tick();
    rst = 1'b0;
    run_trap("postrst", 2'b01, 64'h8020_0800, 64'd8, 64'h8020_0000);

`ifdef TRAP_CTRL_TIMER_IRQ_EN
    // mtime is well past 20 by now; mtimecmp is still all ones.
    sstatus = 64'h2;
    ex_valid = 1'b1; ex_op = 2'b00; ex_pc = 64'h8020_0900;
    tick();
    check("irq_masked_by_cmp", 64'(flush), 64'd0);
    ex_valid = 1'b0;
    timer_cmp_we = 1'b1; timer_cmp_wdata = 64'd20;
    tick();
    timer_cmp_we = 1'b0;
    ex_valid = 1'b1; ex_op = 2'b00; ex_pc = 64'h8020_0a00;
    tick();
    ex_valid = 1'b0;
    check("irq_flush", 64'(flush), 64'd1);
    tick(); tick();
    check("irq_trap", 64'(trap), 64'd1);
    check("irq_pc", trap_pc, 64'h8020_0a00);
    check("irq_cause", trap_scause, 64'h8000_0000_0000_0005);
    tick();
    check("irq_rpc", redirect_pc, 64'h8020_0000);
    tick();
    ex_valid = 1'b1; ex_op = 2'b01; ex_pc = 64'h8020_0b00;
    tick();
    ex_op = 2'b00; ex_pc = 64'h8020_0c00;
    tick(); tick();
    check("prio_cause", trap_scause, 64'd8);
    check("prio_pc", trap_pc, 64'h8020_0b00);
    tick(); tick();
    check("prio_idle", 64'(stall), 64'd0);
    tick();
    ex_valid = 1'b0;
    check("pend_flush", 64'(flush), 64'd1);
    tick(); tick();
    check("pend_cause", trap_scause, 64'h8000_0000_0000_0005);
    check("pend_pc", trap_pc, 64'h8020_0c00);
    tick(); tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
